// File: rtl/vdp_cpu_port.sv
// vdp_cpu_port: CPU-side port of a TMS9918-style video display processor.
// Two-byte control writes, data port into VRAM through a one-entry pending
// slot, status flags and frame interrupt.
// Optional macro VDP_READ_AHEAD_EN: data-port reads are served from a read
// buffer that is refilled by a prefetch. Otherwise reads wait for VRAM.
module vdp_cpu_port #(
    parameter int NUM_REGS = 8,
    parameter int VRAM_AW  = 14
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  io_wr,
    input  logic                  io_rd,
    input  logic                  port_sel,
    input  logic [7:0]            cpu_din,
    output logic [7:0]            cpu_dout,
    output logic                  cpu_wait_n,
    output logic                  vram_req,
    output logic                  vram_we,
    output logic [VRAM_AW-1:0]    vram_addr,
    output logic [7:0]            vram_wdata,
    input  logic                  vram_ack,
    input  logic [7:0]            vram_rdata,
    output logic [NUM_REGS*8-1:0] regs_flat,
    input  logic                  frame_set,
    input  logic                  coll_set,
    input  logic                  fifth_set,
    input  logic [4:0]            fifth_num,
    output logic                  n_int
);
`ifdef VDP_READ_AHEAD_EN
    localparam bit RA = 1'b1;
`else
    localparam bit RA = 1'b0;
`endif
    // 17-bit mode always needs register 14 for the high address bits, even
    // when it is not CPU-visible.
    localparam int NR     = (VRAM_AW == 17 && NUM_REGS < 15) ? 15 : NUM_REGS;
    localparam int HI_IDX = (NR > 14) ? 14 : 0;

    typedef struct packed {
        logic       we;
        logic [7:0] wdata;
    } vreq_t;

    logic [7:0]         regs [NR];
    logic [13:0]        addr, addr_base, addr_inc;
    logic               carry, inc;
    logic               toggle;
    logic [7:0]         first_byte, rbuf, dout_q, status;
    logic               f_flag, s5_flag, c_flag;
    logic [4:0]         fifth_lat;
    logic               pend_vld, new_vld, issue, park;
    vreq_t              pend, new_req, iss_req;
    logic [VRAM_AW-1:0] iss_addr;
    logic               ctl_wr, ctl_2nd, ctl_set, reg_wr;
    logic               dat_wr, dat_rd, sts_rd, ack;

    assign ctl_wr  = io_wr & port_sel;
    assign ctl_2nd = ctl_wr & toggle;
    assign reg_wr  = ctl_2nd & cpu_din[7];
    assign ctl_set = ctl_2nd & ~cpu_din[7];
    assign dat_wr  = io_wr & ~port_sel;
    assign dat_rd  = io_rd & ~port_sel;
    assign sts_rd  = io_rd & port_sel;
    assign ack     = vram_req & vram_ack;   // stray acks after reset are ignored

    // A new VRAM access: data write, data read, or a read-setup prefetch.
    assign new_vld = dat_wr | dat_rd | (RA & ctl_set & ~cpu_din[6]);
    assign new_req = '{we: dat_wr, wdata: cpu_din};

    // The parked entry always goes first; a new access parks when the bus is
    // busy or the slot is being drained this cycle, and is dropped if both.
    assign issue   = ~vram_req & (pend_vld | new_vld);
    assign iss_req = pend_vld ? pend : new_req;
    assign park    = new_vld & (vram_req ^ pend_vld);

    // Address: a control set takes effect immediately so a prefetch can use it.
    assign addr_base        = ctl_set ? {cpu_din[5:0], first_byte} : addr;
    assign inc              = (issue & iss_req.we) | (ack & ~vram_we & ~ctl_set);
    assign {carry, addr_inc} = {1'b0, addr_base} + 15'd1;

    generate
        if (VRAM_AW == 17) begin : g_a17
            assign iss_addr = {regs[HI_IDX][2:0], addr_base};
        end else begin : g_a14
            assign iss_addr = addr_base;
        end
    endgenerate

    assign status     = {f_flag, s5_flag, c_flag, s5_flag ? fifth_lat : 5'h1F};
    assign cpu_wait_n = ~(pend_vld | (~RA & vram_req & ~vram_we));

    // Read data is visible in the same cycle as the strobe, then held.
    always_comb begin
        cpu_dout = dout_q;
        if (sts_rd)            cpu_dout = status;
        else if (RA && dat_rd) cpu_dout = rbuf;
    end

    // Control registers: CPU writes, plus the carry into register 14.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NR; i++) regs[i] <= '0;
        end else begin
            for (int i = 0; i < NR; i++) begin
                if (VRAM_AW == 17 && i == HI_IDX && inc && carry)
                    regs[i][2:0] <= regs[i][2:0] + 3'd1;
                if (reg_wr && i < NUM_REGS && cpu_din[5:0] == 6'(i))
                    regs[i] <= first_byte;
            end
        end
    end

    // Byte toggle, address, VRAM request, pending slot and read data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            toggle     <= 1'b0;
            first_byte <= '0;
            addr       <= '0;
            pend_vld   <= 1'b0;
            pend       <= '0;
            vram_req   <= 1'b0;
            vram_we    <= 1'b0;
            vram_addr  <= '0;
            vram_wdata <= '0;
            rbuf       <= '0;
            dout_q     <= '0;
        end else begin
            if (ctl_wr) begin
                toggle <= ~toggle;
                if (!toggle) first_byte <= cpu_din;
            end else if (dat_wr || sts_rd) begin
                toggle <= 1'b0;
            end
            addr <= inc ? addr_inc : addr_base;
            if (ack) begin
                vram_req <= 1'b0;
            end else if (issue) begin
                vram_req   <= 1'b1;
                vram_we    <= iss_req.we;
                vram_wdata <= iss_req.wdata;
                vram_addr  <= iss_addr;
            end
            if (park) begin
                pend_vld <= 1'b1;
                pend     <= new_req;
            end else if (issue && pend_vld) begin
                pend_vld <= 1'b0;
            end
            if (dat_wr)                       rbuf <= cpu_din;
            else if (RA && ack && !vram_we)   rbuf <= vram_rdata;
            if (sts_rd)                       dout_q <= status;
            else if (RA && dat_rd)            dout_q <= rbuf;
            else if (!RA && ack && !vram_we)  dout_q <= vram_rdata;
        end
    end

    // Status flags: a set pulse beats the clear of a coincident status read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            f_flag    <= 1'b0;
            s5_flag   <= 1'b0;
            c_flag    <= 1'b0;
            fifth_lat <= '0;
            n_int     <= 1'b1;
        end else begin
            if (frame_set)   f_flag <= 1'b1;
            else if (sts_rd) f_flag <= 1'b0;
            if (coll_set)    c_flag <= 1'b1;
            else if (sts_rd) c_flag <= 1'b0;
            if (fifth_set) begin
                s5_flag <= 1'b1;
                if (!s5_flag) fifth_lat <= fifth_num;
            end else if (sts_rd) begin
                s5_flag <= 1'b0;
            end
            n_int <= ~(f_flag & regs[1][5]);
        end
    end

    generate
        for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
            assign regs_flat[8*g +: 8] = regs[g];
        end
    endgenerate
endmodule

// File: tb/tb_vdp_cpu_port.sv
// Directed bench for vdp_cpu_port: default instance (8 regs, 14-bit VRAM)
// plus a 16-register 17-bit instance sharing the CPU-side stimulus.
module tb_vdp_cpu_port;
    logic clk = 1'b0, reset_n = 1'b0;
    logic io_wr = 1'b0, io_rd = 1'b0, port_sel = 1'b0;
    logic [7:0] cpu_din = '0;
    logic frame_set = 1'b0, coll_set = 1'b0, fifth_set = 1'b0;
    logic [4:0] fifth_num = '0;

    logic [7:0]   a_dout, a_wdata, a_rdata = '0;
    logic         a_wait_n, a_req, a_we, a_ack = 1'b0, a_nint;
    logic [13:0]  a_addr;
    logic [63:0]  a_regs;
    logic [7:0]   b_dout, b_wdata, b_rdata = '0;
    logic         b_wait_n, b_req, b_we, b_ack = 1'b0, b_nint;
    logic [16:0]  b_addr;
    logic [127:0] b_regs;

    int n_chk = 0, n_fail = 0, n_issue = 0, a_cnt = 0;
    logic [7:0]  mem [0:16383];
    logic [16:0] b_last_addr = '0;
    logic [7:0]  d;
    int n0;

    vdp_cpu_port u_dut (
        .clk(clk), .reset_n(reset_n), .io_wr(io_wr), .io_rd(io_rd), .port_sel(port_sel),
        .cpu_din(cpu_din), .cpu_dout(a_dout), .cpu_wait_n(a_wait_n),
        .vram_req(a_req), .vram_we(a_we), .vram_addr(a_addr), .vram_wdata(a_wdata),
        .vram_ack(a_ack), .vram_rdata(a_rdata), .regs_flat(a_regs),
        .frame_set(frame_set), .coll_set(coll_set), .fifth_set(fifth_set),
        .fifth_num(fifth_num), .n_int(a_nint));

    vdp_cpu_port #(.NUM_REGS(16), .VRAM_AW(17)) u_dut17 (
        .clk(clk), .reset_n(reset_n), .io_wr(io_wr), .io_rd(io_rd), .port_sel(port_sel),
        .cpu_din(cpu_din), .cpu_dout(b_dout), .cpu_wait_n(b_wait_n),
        .vram_req(b_req), .vram_we(b_we), .vram_addr(b_addr), .vram_wdata(b_wdata),
        .vram_ack(b_ack), .vram_rdata(b_rdata), .regs_flat(b_regs),
        .frame_set(frame_set), .coll_set(coll_set), .fifth_set(fifth_set),
        .fifth_num(fifth_num), .n_int(b_nint));

    always #5 clk = ~clk;

    // VRAM model for the default instance: ack three cycles after request.
    always @(negedge clk) begin
        if (!reset_n) begin
            a_ack = 1'b0;
            a_cnt = 0;
            for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
        end else if (a_ack) begin
            a_ack = 1'b0;
            a_cnt = 0;
        end else if (a_req) begin
            if (a_cnt == 0) n_issue++;
            a_cnt++;
            if (a_cnt >= 3) begin
                a_ack   = 1'b1;
                a_rdata = mem[a_addr];
                if (a_we) mem[a_addr] = a_wdata;
            end
        end
    end

    // VRAM model for the 17-bit instance: ack one cycle after request.
    always @(negedge clk) begin
        if (!reset_n) b_ack = 1'b0;
        else begin
            b_ack = b_req && !b_ack;
            if (b_ack && b_we) b_last_addr = b_addr;
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic wr(input logic sel, input logic [7:0] v);
        io_wr = 1'b1; port_sel = sel; cpu_din = v;
        cyc();
        io_wr = 1'b0;
    endtask

    // Read strobe; captures cpu_dout while the strobe is active.
    task automatic rd(input logic sel, output logic [7:0] v);
        io_rd = 1'b1; port_sel = sel;
        #1 v = a_dout;
        cyc();
        io_rd = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (!(a_req === 1'b0 && a_wait_n === 1'b1 && b_req === 1'b0 && b_wait_n === 1'b1)
               && k < 40) begin
            cyc();
            k++;
        end
        chk("idle_timeout", k < 40, 1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dout", a_dout, 8'h00);
        chk("rst_wait_n", a_wait_n, 1);
        chk("rst_nint", a_nint, 1);
        chk("rst_req", a_req, 0);
        chk("rst_regs", a_regs, 0);
        chk("rst_regs17", b_regs, 0);
        reset_n = 1'b1;
        cyc();

        // 17-bit carry into register 14; 14-bit wrap on the default instance
        wr(1, 8'h03); wr(1, 8'h8E);
        wr(1, 8'hFF); wr(1, 8'h7F);
        wr(0, 8'h5A);
        chk("a17_addr", b_addr, 17'h0FFFF);
        chk("a17_we", b_we, 1);
        chk("a17_reg14", b_regs[119:112], 8'h04);
        chk("a14_addr_top", a_addr, 14'h3FFF);
        wait_idle();
        chk("a17_written", b_last_addr, 17'h0FFFF);
        chk("a14_mem_top", mem[14'h3FFF], 8'h5A);
        wr(0, 8'h5B);
        chk("a17_next", b_addr, 17'h10000);
        chk("a14_wrap", a_addr, 14'h0000);
        wait_idle();

        // Register writes
        n0 = n_issue;
        wr(1, 8'h07); wr(1, 8'h81);
        chk("reg1", a_regs[15:8], 8'h07);
        chk("regs_all", a_regs, 64'h0700);
        cyc();
        chk("reg_no_vram", n_issue, n0);
        wr(1, 8'h5A); wr(1, 8'h88);
        chk("reg_idx_oob", a_regs, 64'h0700);
        wr(1, 8'hC3); wr(1, 8'h87);
        chk("reg7", a_regs, 64'hC300_0000_0000_0700);

        // Data writes with a parked second write
        wr(1, 8'h34); wr(1, 8'h52);
        wr(0, 8'hAA);
        chk("w1_req", a_req, 1);
        chk("w1_addr", a_addr, 14'h1234);
        chk("w1_data", a_wdata, 8'hAA);
        wr(0, 8'hBB);
        chk("w2_parked", a_wait_n, 0);
        chk("w2_hold_addr", a_addr, 14'h1234);
        for (int k = 0; k < 20 && !(a_req === 1'b1 && a_addr === 14'h1235); k++) cyc();
        chk("w2_issue_addr", a_addr, 14'h1235);
        chk("w2_wait_rel", a_wait_n, 1);
        chk("w2_data", a_wdata, 8'hBB);
        wait_idle();
        chk("mem1234", mem[14'h1234], 8'hAA);
        chk("mem1235", mem[14'h1235], 8'hBB);

        // Third write while one is parked is dropped
        wr(1, 8'h00); wr(1, 8'h41);
        wr(0, 8'h01); wr(0, 8'h02); wr(0, 8'h03);
        wait_idle();
        chk("mem0100", mem[14'h0100], 8'h01);
        chk("mem0101", mem[14'h0101], 8'h02);
        chk("drop_0102", mem[14'h0102], 8'h00);
        wr(0, 8'h44);
        wait_idle();
        chk("after_drop", mem[14'h0102], 8'h44);

        // Data reads
        wr(1, 8'h00); wr(1, 8'h40);
        wr(0, 8'h11); wr(0, 8'h22);
        wait_idle();
        n0 = n_issue;
        wr(1, 8'h00); wr(1, 8'h00);
`ifdef VDP_READ_AHEAD_EN
        chk("pf_req", a_req, 1);
        chk("pf_we", a_we, 0);
        chk("pf_addr", a_addr, 14'h0000);
        wait_idle();
        rd(0, d);
        chk("ra_rd1", d, 8'h11);
        wait_idle();
        rd(0, d);
        chk("ra_rd2", d, 8'h22);
        chk("ra_pf_addr", a_addr, 14'h0002);
        chk("ra_pf_req", a_req, 1);
        chk("ra_dout_hold", a_dout, 8'h22);
        wait_idle();
`else
        cyc();
        chk("rs_no_pf", n_issue, n0);
        rd(0, d);
        chk("rd1_req", a_req, 1);
        chk("rd1_we", a_we, 0);
        chk("rd1_addr", a_addr, 14'h0000);
        chk("rd1_wait", a_wait_n, 0);
        wait_idle();
        chk("rd1_data", a_dout, 8'h11);
        rd(0, d);
        wait_idle();
        chk("rd2_data", a_dout, 8'h22);
        rd(0, d);
        chk("rd3_addr", a_addr, 14'h0002);
        wait_idle();
`endif

        // Frame interrupt and status read
        wr(1, 8'h20); wr(1, 8'h81);
        frame_set = 1'b1; cyc(); frame_set = 1'b0;
        chk("nint_lag", a_nint, 1);
        cyc();
        chk("nint_low", a_nint, 0);
        rd(1, d);
        chk("status_F", d, 8'h9F);
        cyc();
        chk("nint_high", a_nint, 1);
        rd(1, d);
        chk("status_clr", d, 8'h1F);

        // Fifth sprite and collision flags
        fifth_set = 1'b1; fifth_num = 5'd5; cyc();
        fifth_num = 5'd9; cyc();
        fifth_set = 1'b0; coll_set = 1'b1; cyc();
        coll_set = 1'b0;
        rd(1, d);
        chk("status_5s_c", d, 8'h65);
        rd(1, d);
        chk("status_5s_clr", d, 8'h1F);

        // Set pulse coincident with a status read survives the clear
        frame_set = 1'b1;
        rd(1, d);
        frame_set = 1'b0;
        chk("set_vs_rd_old", d, 8'h1F);
        rd(1, d);
        chk("set_vs_rd_kept", d, 8'h9F);

        // Status read clears a half-written control pair
        wr(1, 8'h55);
        rd(1, d);
        chk("toggle_rd", d, 8'h1F);
        wr(1, 8'h00); wr(1, 8'h40);
        wr(0, 8'h77);
        chk("toggle_addr", a_addr, 14'h0000);
        chk("toggle_we", a_we, 1);
        wait_idle();

        // Reset during an outstanding request
        wr(0, 8'h66);
        chk("mid_req", a_req, 1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_req", a_req, 0);
        chk("mid_rst_wait", a_wait_n, 1);
        chk("mid_rst_regs", a_regs, 0);
        chk("mid_rst_dout", a_dout, 8'h00);
        repeat (2) cyc();
        reset_n = 1'b1;
        repeat (4) cyc();
        chk("post_rst_req", a_req, 0);
        chk("post_rst_nint", a_nint, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
